jellyvl_etherneco_frame_tx: RTL and testbench

Ethernet framing stage sitting directly downstream of the EtherNeco packet transmitter on each ring port. It takes the packet byte stream (first/last/data/valid/ready), and emits a complete wire frame toward the PHY byte interface. The wire frame is preamble, SFD, payload, zero padding to the minimum length, CRC-32 FCS, then a guaranteed inter-frame gap. It also detects upstream underrun and malformed framing, and poisons the FCS of the affected frame so that the receiving node drops it.

---
 rtl/jellyvl_etherneco_pkg.sv | 35 +++
 rtl/jellyvl_ether_crc32.sv | 38 +++
 rtl/jellyvl_etherneco_frame_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_jellyvl_etherneco_frame_tx.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jellyvl_etherneco_pkg.sv
// EtherNeco framing shared definitions.
// Wire constants, CRC-32 parameters and tx state type.
package jellyvl_etherneco_pkg;

    localparam logic [7:0]  ETHER_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETHER_SFD      = 8'hD5;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } state_t;

    // One byte step of the reflected CRC-32 register.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/jellyvl_ether_crc32.sv
// Byte-wise CRC-32 accumulator.
// Holds the raw reflected state; the caller applies the final XOR.
module jellyvl_ether_crc32
    import jellyvl_etherneco_pkg::*;
(
    input  logic        reset,
    input  logic        clk,
    input  logic        clear_i,
    input  logic        update_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next CRC: clear wins over update.
    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC32_INIT;
        end else if (update_i) begin
            crc_d = crc32_byte(crc_q, data_i);
        end
    end

    // CRC state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/jellyvl_etherneco_frame_tx.sv
// EtherNeco wire framer: preamble, SFD, payload, pad, FCS, IFG.
// Underrun or a stray first beat poisons the FCS of the frame.
module jellyvl_etherneco_frame_tx
    import jellyvl_etherneco_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_LEN      = 12
)
(
    input  logic       reset,
    input  logic       clk,

    input  logic       s_first,
    input  logic       s_last,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,

    output logic       m_first,
    output logic       m_last,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,

    output logic       underrun
);

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
    localparam state_t      ST_START = (PREAMBLE_LEN == 1) ? ST_SFD
                                                           : ST_PREAMBLE;

    state_t      state_q, state_d;
    logic [15:0] sub_q, sub_d;
    logic [15:0] cnt_q, cnt_d;
    logic        head_q, head_d;
    logic        poison_q, poison_d;

    logic        m_valid_q, m_valid_d;
    logic        m_first_q, m_first_d;
    logic        m_last_q, m_last_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        underrun_q, underrun_d;

    logic        adv;
    logic        bad_first;
    logic [15:0] cnt_inc;
    logic        short_frame;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic        crc_clear;
    logic        crc_update;
    logic [7:0]  crc_data;
    logic        s_ready_c;

    jellyvl_ether_crc32 u_crc (
        .reset    (reset),
        .clk      (clk),
        .clear_i  (crc_clear),
        .update_i (crc_update),
        .data_i   (crc_data),
        .crc_o    (crc)
    );

    assign adv         = m_ready | ~m_valid_q;
    assign bad_first   = s_valid & s_first & ~head_q;
    assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign short_frame = cnt_inc < MIN_CNT;
    // Poisoned frames send the raw state, i.e. the complemented FCS.
    assign fcs         = poison_q ? crc : (crc ^ CRC32_XOROUT);

    // Next-state and output-register load for each wire slot.
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        poison_d   = poison_q;
        m_valid_d  = m_valid_q;
        m_first_d  = m_first_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        underrun_d = 1'b0;
        crc_clear  = 1'b0;
        crc_update = 1'b0;
        crc_data   = 8'h00;
        s_ready_c  = 1'b0;

        if (adv) begin
            m_first_d = 1'b0;
            m_last_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                s_ready_c = ~s_first;
                if (s_valid && s_first) begin
                    m_valid_d = 1'b1;
                    m_first_d = 1'b1;
                    m_data_d  = ETHER_PREAMBLE;
                    sub_d     = 16'd1;
                    cnt_d     = 16'd0;
                    head_d    = 1'b1;
                    poison_d  = 1'b0;
                    crc_clear = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_PREAMBLE: begin
                if (adv) begin
                    m_data_d = ETHER_PREAMBLE;
                    sub_d    = sub_q + 16'd1;
                    if (sub_q == PRE_LAST) begin
                        state_d = ST_SFD;
                    end
                end
            end
            ST_SFD: begin
                if (adv) begin
                    m_data_d = ETHER_SFD;
                    state_d  = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                s_ready_c = adv & ~bad_first;
                sub_d     = 16'd0;
                if (adv) begin
                    crc_update = 1'b1;
                    cnt_d      = cnt_inc;
                    if (s_valid && !bad_first) begin
                        m_data_d = s_data;
                        crc_data = s_data;
                        head_d   = 1'b0;
                        if (s_last) begin
                            state_d = short_frame ? ST_PAD : ST_FCS;
                        end
                    end else begin
                        m_data_d   = 8'h00;
                        poison_d   = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = short_frame ? ST_PAD : ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                sub_d = 16'd0;
                if (adv) begin
                    m_data_d   = 8'h00;
                    crc_update = 1'b1;
                    cnt_d      = cnt_inc;
                    if (!short_frame) begin
                        state_d = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                if (adv) begin
                    m_data_d = fcs[{sub_q[1:0], 3'b000} +: 8];
                    sub_d    = sub_q + 16'd1;
                    if (sub_q[1:0] == 2'd3) begin
                        m_last_d = 1'b1;
                        sub_d    = 16'd0;
                        state_d  = ST_IFG;
                    end
                end
            end
            ST_IFG: begin
                if (adv) begin
                    m_valid_d = 1'b0;
                end
                if (!m_valid_q && m_ready) begin
                    sub_d = sub_q + 16'd1;
                    if (sub_q == IFG_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sub_q      <= 16'd0;
            cnt_q      <= 16'd0;
            head_q     <= 1'b0;
            poison_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_first_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= 8'h00;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            poison_q   <= poison_d;
            m_valid_q  <= m_valid_d;
            m_first_q  <= m_first_d;
            m_last_q   <= m_last_d;
            m_data_q   <= m_data_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_ready  = s_ready_c;
    assign m_valid  = m_valid_q;
    assign m_first  = m_first_q;
    assign m_last   = m_last_q;
    assign m_data   = m_data_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_jellyvl_etherneco_frame_tx.sv
// Bench for jellyvl_etherneco_frame_tx.
// Packet-level reference model plus per-cycle wire checks.
module tb_jellyvl_etherneco_frame_tx;

    localparam int PRE  = 7;
    localparam int MINF = 60;
    localparam int IFG  = 12;

    typedef struct packed {
        logic       f;
        logic       l;
        logic [7:0] d;
    } wb_t;

    typedef struct {
        logic [7:0] d;
        bit         f;
        bit         l;
        bit         g;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       s_first, s_last, s_valid, s_ready;
    logic [7:0] s_data;
    logic       m_first, m_last, m_valid, m_ready;
    logic [7:0] m_data;
    logic       underrun;

    logic       s0_first, s0_last, s0_valid, s0_ready;
    logic [7:0] s0_data;
    logic       m0_first, m0_last, m0_valid, m0_ready;
    logic [7:0] m0_data;
    logic       u0;

    always #5 clk = ~clk;

    jellyvl_etherneco_frame_tx #(
        .PREAMBLE_LEN (PRE),
        .MIN_FRAME    (MINF),
        .IFG_LEN      (IFG)
    ) dut (
        .reset    (reset),
        .clk      (clk),
        .s_first  (s_first),
        .s_last   (s_last),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_first  (m_first),
        .m_last   (m_last),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .underrun (underrun)
    );

    jellyvl_etherneco_frame_tx #(
        .PREAMBLE_LEN (7),
        .MIN_FRAME    (0),
        .IFG_LEN      (12)
    ) dut0 (
        .reset    (reset),
        .clk      (clk),
        .s_first  (s0_first),
        .s_last   (s0_last),
        .s_data   (s0_data),
        .s_valid  (s0_valid),
        .s_ready  (s0_ready),
        .m_first  (m0_first),
        .m_last   (m0_last),
        .m_data   (m0_data),
        .m_valid  (m0_valid),
        .m_ready  (m0_ready),
        .underrun (u0)
    );

    int   vectors = 0;
    int   errors = 0;
    int   exp_under = 0;
    int   got_under = 0;
    int   rmode = 0;
    wb_t  exp_q[$];
    wb_t  got0[$];
    ent_t sc[$];
    logic [7:0] mpl[$];
    bit   m_in = 0;

    bit   in_frame = 0;
    bit   have_prev = 0;
    bit   stall = 0;
    logic [10:0] stall_v;
    int   pos = 0;
    int   idle = 0;

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endfunction

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic void push_w(logic f, logic l, logic [7:0] d);
        wb_t w;
        w.f = f;
        w.l = l;
        w.d = d;
        exp_q.push_back(w);
    endfunction

    // Whole expected wire frame for one payload.
    function automatic void model_frame(input logic [7:0] pl[$],
                                        input bit poison);
        logic [7:0]  b[$];
        logic [31:0] fcs;
        b = pl;
        while (b.size() < MINF) b.push_back(8'h00);
        fcs = crc32(b);
        if (poison) fcs = ~fcs;
        for (int i = 0; i < PRE; i++) push_w(i == 0, 1'b0, 8'h55);
        push_w(1'b0, 1'b0, 8'hD5);
        foreach (b[i]) push_w(1'b0, 1'b0, b[i]);
        for (int i = 0; i < 4; i++) push_w(1'b0, i == 3, fcs[8*i +: 8]);
    endfunction

    // Packet-level interpretation of the planned input stream.
    function automatic void model_run();
        foreach (sc[i]) begin
            if (sc[i].g && m_in) begin
                mpl.push_back(8'h00);
                model_frame(mpl, 1'b1);
                exp_under++;
                m_in = 0;
            end
            if (sc[i].f) begin
                if (m_in) begin
                    mpl.push_back(8'h00);
                    model_frame(mpl, 1'b1);
                    exp_under++;
                end
                mpl.delete();
                mpl.push_back(sc[i].d);
                m_in = 1;
                if (sc[i].l) begin
                    model_frame(mpl, 1'b0);
                    m_in = 0;
                end
            end else if (m_in) begin
                mpl.push_back(sc[i].d);
                if (sc[i].l) begin
                    model_frame(mpl, 1'b0);
                    m_in = 0;
                end
            end
        end
    endfunction

    function automatic void add(logic [7:0] d, bit f, bit l, bit g);
        ent_t e;
        e.d = d;
        e.f = f;
        e.l = l;
        e.g = g;
        sc.push_back(e);
    endfunction

    task automatic put(input ent_t e);
        bit ok;
        ok = 0;
        s_data  = e.d;
        s_first = e.f;
        s_last  = e.l;
        s_valid = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL put_timeout got s_ready=0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gap_slot();
        bit ok;
        ok = 0;
        s_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL gap_timeout got m_ready=0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        model_run();
        foreach (sc[i]) begin
            if (sc[i].g) gap_slot();
            put(sc[i]);
        end
        s_valid = 1'b0;
        s_first = 1'b0;
        s_last  = 1'b0;
        sc.delete();
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 8000; n++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        #1;
        chk("drain_done", 32'(ok), 32'd1);
    endtask

    // PHY strobe pattern.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Wire-side compare against the model, every cycle.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_frame  = 0;
                have_prev = 0;
                stall     = 0;
                idle      = 0;
            end else begin
                if (underrun) got_under++;
                if (stall) begin
                    chk("stall_hold",
                        32'({m_valid, m_first, m_last, m_data}),
                        32'(stall_v));
                end
                if (in_frame) chk("valid_in_frame", 32'(m_valid), 32'd1);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte",
                            32'({m_first, m_last, m_data}), 32'h3FF);
                    end else begin
                        w = exp_q.pop_front();
                        chk($sformatf("wire_byte_%0d", pos),
                            32'({m_first, m_last, m_data}), 32'(w));
                    end
                    if (m_first) begin
                        if (have_prev) begin
                            chk("ifg_ok", 32'(idle >= IFG), 32'd1);
                        end
                        in_frame = 1;
                        pos      = 0;
                    end
                    pos++;
                    if (m_last) begin
                        in_frame  = 0;
                        have_prev = 1;
                        idle      = 0;
                    end
                end
                if (!m_valid && m_ready) idle++;
                stall   = m_valid && !m_ready;
                stall_v = {m_valid, m_first, m_last, m_data};
            end
        end
    end

    // Second instance collector.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (reset && m0_valid && m0_ready) begin
                w.f = m0_first;
                w.l = m0_last;
                w.d = m0_data;
                got0.push_back(w);
            end
        end
    end

    initial begin
        logic [7:0] e0[21];
        logic [7:0] pl[$];
        int         len;
        int         gi;
        bit         ok;

        e0 = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
               8'hD5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
               8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

        s_first = 0; s_last = 0; s_valid = 0; s_data = 0;
        s0_first = 0; s0_last = 0; s0_valid = 0; s0_data = 0;
        m0_ready = 1'b1;

        #1 reset = 1'b0;
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_first", 32'(m_first), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // "123456789" through the no-pad instance.
        for (int i = 0; i < 9; i++) begin
            s0_data  = 8'(8'h31 + i);
            s0_first = (i == 0);
            s0_last  = (i == 8);
            s0_valid = 1'b1;
            ok = 0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (s0_ready) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) begin
                errors++;
                $display("FAIL put0_timeout got s_ready=0 want 1");
            end
            @(posedge clk);
            #1;
        end
        s0_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("nopad_len", 32'(got0.size()), 32'd21);
        for (int i = 0; i < 21 && i < got0.size(); i++) begin
            chk($sformatf("nopad_byte_%0d", i), 32'(got0[i]),
                32'({i == 0, i == 20, e0[i]}));
        end

        // 1-byte payload, padded.
        rmode = 0;
        add(8'hAB, 1, 1, 0);
        drive();

        // 64 bytes, free running then strobed 1/0.
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
        foreach (pl[i]) add(pl[i], i == 0, i == 63, 0);
        drive();
        drain();
        rmode = 1;
        foreach (pl[i]) add(pl[i], i == 0, i == 63, 0);
        drive();
        drain();

        // Underrun after 5 of 20 bytes.
        rmode = 0;
        for (int i = 0; i < 20; i++) add(8'($urandom), i == 0, i == 19, i == 5);
        drive();

        // Stray first on byte 10.
        for (int i = 0; i < 20; i++) begin
            add(8'($urandom), (i == 0) || (i == 9), i == 19, 0);
        end
        drive();

        // Stray bytes before a packet.
        add(8'h11, 0, 0, 0);
        add(8'h22, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(8'(8'hC0 + i), i == 0, i == 2, 0);
        drive();

        // Random packets, strobe patterns and underruns.
        for (int p = 0; p < 14; p++) begin
            rmode = $urandom_range(0, 2);
            len   = $urandom_range(1, 80);
            gi    = -1;
            if (len >= 2 && $urandom_range(0, 4) == 0) begin
                gi = $urandom_range(1, len - 1);
            end
            for (int i = 0; i < len; i++) begin
                add(8'($urandom), i == 0, i == len - 1, i == gi);
            end
            drive();
        end
        rmode = 0;
        drain();

        // Reset in the FCS of a frame.
        for (int i = 0; i < 20; i++) add(8'($urandom), i == 0, i == 19, 0);
        drive();
        ok = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            if (in_frame && pos >= 70) begin
                ok = 1;
                break;
            end
        end
        chk("reach_fcs", 32'(ok), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_first", 32'(m_first), 32'd0);
        chk("midrst_m_last", 32'(m_last), 32'd0);
        chk("midrst_m_data", 32'(m_data), 32'd0);
        chk("midrst_underrun", 32'(underrun), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) add(8'($urandom), i == 0, i == 9, 0);
        drive();
        drain();
        repeat (30) @(posedge clk);
        #1;

        chk("underrun_count", 32'(got_under), 32'(exp_under));
        chk("exp_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
